// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port, write-first data memory with a one-cycle read.
// Optional grant/conflict statistics are compiled in with `define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = DATA_WIDTH,
    parameter int DATA_BYTES = DATA_WIDTH / 8,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_lock,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic [DATA_BYTES-1:0] p0_wen,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_lock,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic [DATA_BYTES-1:0] p1_wen,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [DATA_BYTES-1:0] m_wen,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic [1:0]            dbg_state
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]           o_gnt0_cnt,
    output logic [31:0]           o_gnt1_cnt,
    output logic [31:0]           o_conflict_cnt
`endif
);

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] MAX_WAIT_W = WCW'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t         state, state_d;
    logic [WCW-1:0] wait_cnt;
    logic           rsp_valid;
    logic           rsp_port;
    logic [DATA_WIDTH-1:0] p0_rdata_q, p1_rdata_q;

    assign dbg_state = state;

    // Handshake: a requester holds req and its payload stable until gnt; gnt high in a
    // cycle means that beat is presented to memory this cycle, and its response
    // (rvalid, one cycle wide) follows exactly one cycle later. There is no backpressure.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            case (state)
                ST_ARB: begin
                    if (p1_req && wait_cnt == MAX_WAIT_W) p1_gnt = 1'b1;
                    else if (p0_req)                      p0_gnt = 1'b1;
                    else if (p1_req)                      p1_gnt = 1'b1;
                end
                ST_LOCK0: p0_gnt = p0_req;
                ST_LOCK1: p1_gnt = p1_req;
                default: ;
            endcase
        end
    end

    // A lock only takes effect on a granted beat; anything else falls back to ARB.
    always_comb begin
        state_d = ST_ARB;
        if (p0_gnt && p0_lock)      state_d = ST_LOCK0;
        else if (p1_gnt && p1_lock) state_d = ST_LOCK1;
    end

    always_comb begin
        m_addr  = '0;
        m_wdata = '0;
        m_wen   = '0;
        if (p0_gnt) begin
            m_addr  = p0_addr;
            m_wdata = p0_wdata;
            m_wen   = p0_wen;
        end else if (p1_gnt) begin
            m_addr  = p1_addr;
            m_wdata = p1_wdata;
            m_wen   = p1_wen;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_ARB;
            wait_cnt   <= '0;
            rsp_valid  <= 1'b0;
            rsp_port   <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state     <= state_d;
            rsp_valid <= p0_gnt | p1_gnt;
            rsp_port  <= p1_gnt;
            if (!p1_req || p1_gnt)        wait_cnt <= '0;
            else if (wait_cnt != MAX_WAIT_W) wait_cnt <= wait_cnt + WCW'(1);
            if (p0_rvalid) p0_rdata_q <= m_rdata;
            if (p1_rvalid) p1_rdata_q <= m_rdata;
        end
    end

    // Memory data is steered straight through in the response cycle, then held.
    assign p0_rvalid = rsp_valid && !rsp_port;
    assign p1_rvalid = rsp_valid && rsp_port;
    assign p0_rdata  = p0_rvalid ? m_rdata : p0_rdata_q;
    assign p1_rdata  = p1_rvalid ? m_rdata : p1_rdata_q;

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_gnt0_cnt     <= '0;
            o_gnt1_cnt     <= '0;
            o_conflict_cnt <= '0;
        end else begin
            if (p0_gnt) o_gnt0_cnt <= o_gnt0_cnt + 32'd1;
            if (p1_gnt) o_gnt1_cnt <= o_gnt1_cnt + 32'd1;
            if (p0_req && p1_req && (p0_gnt ^ p1_gnt))
                o_conflict_cnt <= o_conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a write-first memory model, per-scenario tasks
// checking grants inline, and a response scoreboard fed with expected {port, data}.
module tb_dmem_arbiter;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int BW = 8;
    localparam logic [1:0] S_ARB   = 2'd0;
    localparam logic [1:0] S_LOCK0 = 2'd1;
    localparam logic [1:0] S_LOCK1 = 2'd2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_req, p0_lock, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic [BW-1:0] p0_wen;
    logic          p1_req, p1_lock, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic [BW-1:0] p1_wen;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [BW-1:0] m_wen;
    logic [1:0]    dbg_state;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0]   o_gnt0_cnt, o_gnt1_cnt, o_conflict_cnt;
`endif

    logic [DW:0]   exp_q[$];
    logic [DW:0]   exp_e, act_e;
    logic [DW-1:0] mem[0:15];
    logic [DW-1:0] last_p0;
    int            tests_run = 0;
    int            tests_failed = 0;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_BYTES(BW), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_wen(p0_wen), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_wen(p1_wen), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen), .m_rdata(m_rdata),
        .dbg_state(dbg_state)
`ifdef DMEM_ARB_STATS_EN
        , .o_gnt0_cnt(o_gnt0_cnt), .o_gnt1_cnt(o_gnt1_cnt), .o_conflict_cnt(o_conflict_cnt)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] wd,
                                            input logic [BW-1:0] we);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++) if (we[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Write-first memory, registered read.
    always @(posedge clk) begin
        if (m_wen != '0) mem[m_addr[6:3]] <= merge(mem[m_addr[6:3]], m_wdata, m_wen);
        m_rdata <= merge(mem[m_addr[6:3]], m_wdata, m_wen);
    end

    // ---------------- response scoreboard ----------------
    always @(negedge clk) begin
        if (p0_rvalid && p1_rvalid) begin
            tests_run++;
            tests_failed++;
            $display("FAIL rsp_both: p0_rvalid=1 p1_rvalid=1, required at most one");
        end else if (p0_rvalid || p1_rvalid) begin
            tests_run++;
            act_e = {p1_rvalid, p1_rvalid ? p1_rdata : p0_rdata};
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL rsp_unexpected: got port%0d data %h, required no response",
                         act_e[DW], act_e[DW-1:0]);
            end else begin
                exp_e = exp_q.pop_front();
                if (act_e !== exp_e) begin
                    tests_failed++;
                    $display("FAIL rsp_data: got port%0d %h, required port%0d %h",
                             act_e[DW], act_e[DW-1:0], exp_e[DW], exp_e[DW-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs;
        p0_req = 1'b0; p0_lock = 1'b0; p0_addr = '0; p0_wdata = '0; p0_wen = '0;
        p1_req = 1'b0; p1_lock = 1'b0; p1_addr = '0; p1_wdata = '0; p1_wen = '0;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        idle_inputs();
        p0_req = 1'b1; p0_wen = 8'hFF; p0_addr = 64'h20; p0_wdata = 64'h55;
        p1_req = 1'b1; p1_wen = 8'hFF; p1_addr = 64'h28;
        @(negedge clk);
        tests_run++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_hs: gnt=%b%b rvalid=%b%b, required 0000", p0_gnt, p1_gnt, p0_rvalid, p1_rvalid);
        end
        tests_run++;
        if (m_wen !== '0 || m_addr !== '0 || m_wdata !== '0) begin
            tests_failed++;
            $display("FAIL reset_mem: m_wen=%h m_addr=%h m_wdata=%h, required 0", m_wen, m_addr, m_wdata);
        end
        tests_run++;
        if (p0_rdata !== '0 || p1_rdata !== '0 || dbg_state !== S_ARB) begin
            tests_failed++;
            $display("FAIL reset_regs: p0_rdata=%h p1_rdata=%h state=%0d, required 0 0 ARB", p0_rdata, p1_rdata, dbg_state);
        end
        idle_inputs();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_single_read;
        next_cycle();
        p0_req = 1'b1; p0_addr = 64'h18;
        @(negedge clk);
        tests_run++;
        if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || m_addr !== 64'h18 || m_wen !== '0) begin
            tests_failed++;
            $display("FAIL single_gnt: gnt=%b%b m_addr=%h m_wen=%h, required 10 18 00", p0_gnt, p1_gnt, m_addr, m_wen);
        end
        exp_q.push_back({1'b0, 64'hDEAD});
        last_p0 = 64'hDEAD;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 64'hDEAD || p1_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_rsp: p0_rvalid=%b p0_rdata=%h p1_rvalid=%b, required 1 dead 0", p0_rvalid, p0_rdata, p1_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_write_ack;
        p1_req = 1'b1; p1_addr = 64'h40; p1_wdata = 64'h1234; p1_wen = 8'hFF;
        @(negedge clk);
        tests_run++;
        if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || m_wen !== 8'hFF || m_addr !== 64'h40 || m_wdata !== 64'h1234) begin
            tests_failed++;
            $display("FAIL wr_gnt: gnt=%b%b m_wen=%h m_addr=%h m_wdata=%h, required 01 ff 40 1234",
                     p0_gnt, p1_gnt, m_wen, m_addr, m_wdata);
        end
        exp_q.push_back({1'b1, 64'h1234});
        next_cycle();
        idle_inputs();
        p0_req = 1'b1; p0_addr = 64'h40; p0_wdata = 64'hAB; p0_wen = 8'h01;
        @(negedge clk);
        tests_run++;
        if (p1_rvalid !== 1'b1 || p1_rdata !== 64'h1234 || p0_rvalid !== 1'b0 || p0_rdata !== last_p0) begin
            tests_failed++;
            $display("FAIL wr_ack: p1_rvalid=%b p1_rdata=%h p0_rvalid=%b p0_rdata=%h, required 1 1234 0 %h",
                     p1_rvalid, p1_rdata, p0_rvalid, p0_rdata, last_p0);
        end
        exp_q.push_back({1'b0, 64'h12AB});
        last_p0 = 64'h12AB;
        next_cycle();
        idle_inputs();
        next_cycle();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL wr_drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_simultaneous;
        logic g1;
        for (int c = 1; c <= 18; c++) begin
            p0_req = 1'b1; p0_addr = 64'h20;
            p1_req = 1'b1; p1_addr = 64'h28;
            @(negedge clk);
            g1 = (c % 9 == 0);
            tests_run++;
            if (p0_gnt !== !g1 || p1_gnt !== g1) begin
                tests_failed++;
                $display("FAIL starve_c%0d: gnt=%b%b, required %b%b", c, p0_gnt, p1_gnt, !g1, g1);
            end
            exp_q.push_back({g1, g1 ? mem[5] : mem[4]});
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_lock;
        logic g1;
        for (int c = 1; c <= 13; c++) begin
            p0_req = 1'b1; p0_addr = 64'h08;
            p1_req = (c <= 12); p1_lock = (c <= 11); p1_addr = 64'h10;
            @(negedge clk);
            g1 = (c >= 9 && c <= 12);
            tests_run++;
            if (p0_gnt !== !g1 || p1_gnt !== g1) begin
                tests_failed++;
                $display("FAIL lock_c%0d: gnt=%b%b, required %b%b", c, p0_gnt, p1_gnt, !g1, g1);
            end
            if (c >= 10) begin
                tests_run++;
                if (dbg_state !== ((c == 13) ? S_ARB : S_LOCK1)) begin
                    tests_failed++;
                    $display("FAIL lock_state_c%0d: state=%0d, required %0d", c, dbg_state, (c == 13) ? S_ARB : S_LOCK1);
                end
            end
            exp_q.push_back({g1, g1 ? mem[2] : mem[1]});
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_lock_drop;
        logic [1:0] exp_st[4];
        exp_st[0] = S_ARB; exp_st[1] = S_LOCK0; exp_st[2] = S_LOCK0; exp_st[3] = S_ARB;
        for (int c = 1; c <= 4; c++) begin
            p0_req = (c <= 2); p0_lock = 1'b1; p0_addr = 64'h30;
            p1_req = 1'b1; p1_addr = 64'h38;
            @(negedge clk);
            tests_run++;
            if (p0_gnt !== (c <= 2) || p1_gnt !== (c == 4) || dbg_state !== exp_st[c-1]) begin
                tests_failed++;
                $display("FAIL lockdrop_c%0d: gnt=%b%b state=%0d, required %b%b %0d",
                         c, p0_gnt, p1_gnt, dbg_state, c <= 2, c == 4, exp_st[c-1]);
            end
            if (c <= 2) exp_q.push_back({1'b0, mem[6]});
            if (c == 4) exp_q.push_back({1'b1, mem[7]});
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back;
        int            port, idx;
        logic [DW-1:0] wd;
        logic [BW-1:0] we;
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            port = i % 2;
            idx  = $urandom_range(0, 15);
            wd   = {$urandom, $urandom};
            we   = ($urandom_range(0, 1) == 1) ? BW'($urandom_range(1, 255)) : '0;
            if (port == 0) begin
                p0_req = 1'b1; p0_addr = AW'(idx * 8); p0_wdata = wd; p0_wen = we;
            end else begin
                p1_req = 1'b1; p1_addr = AW'(idx * 8); p1_wdata = wd; p1_wen = we;
            end
            @(negedge clk);
            tests_run++;
            if (p0_gnt !== (port == 0) || p1_gnt !== (port == 1) || m_addr !== AW'(idx * 8) || m_wen !== we) begin
                tests_failed++;
                $display("FAIL b2b_%0d: gnt=%b%b m_addr=%h m_wen=%h, required port%0d %h %h",
                         i, p0_gnt, p1_gnt, m_addr, m_wen, port, idx * 8, we);
            end
            exp_q.push_back({port[0], merge(mem[idx], wd, we)});
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || m_wen !== '0 || m_addr !== '0 || m_wdata !== '0) begin
            tests_failed++;
            $display("FAIL idle_bus: gnt=%b%b m_wen=%h m_addr=%h m_wdata=%h, required all 0",
                     p0_gnt, p1_gnt, m_wen, m_addr, m_wdata);
        end
        next_cycle();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_flight;
        p0_req = 1'b1; p0_lock = 1'b1; p0_addr = 64'h18;
        @(negedge clk);
        tests_run++;
        if (p0_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmid_gnt: p0_gnt=%b, required 1", p0_gnt);
        end
        next_cycle();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || p0_rdata !== '0 || p1_rdata !== '0 ||
            m_wen !== '0 || m_addr !== '0 || dbg_state !== S_ARB) begin
            tests_failed++;
            $display("FAIL rmid_rst: rvalid=%b%b rdata=%h/%h m_wen=%h m_addr=%h state=%0d, required reset values",
                     p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, m_wen, m_addr, dbg_state);
        end
        next_cycle();
        rst = 1'b0;
        p1_req = 1'b1; p1_addr = 64'h48;
        @(negedge clk);
        tests_run++;
        if (p0_rvalid !== 1'b0 || dbg_state !== S_ARB || p1_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmid_after: p0_rvalid=%b state=%0d p1_gnt=%b, required 0 ARB 1", p0_rvalid, dbg_state, p1_gnt);
        end
        exp_q.push_back({1'b1, mem[9]});
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 64'h5A5A_0000_0000_0000 + 64'(i) * 64'h0001_0001;
        mem[3] = 64'hDEAD;
        m_rdata = '0;
        last_p0 = '0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_write_ack();
        test_simultaneous();
        test_lock();
        test_lock_drop();
        test_back_to_back();
        test_reset_mid_flight();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL final_drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the single-port, write-first data memory (one-cycle registered read).
- Port 0 is the core load/store unit; port 1 is a secondary master (loader/DMA/debug).
- Fixed priority to port 0, with a starvation guard for port 1.
- Supports locked multi-beat sequences for read-modify-write (AMO) and steers each one-cycle-late read response back to the requester that issued it.

Parameters:
- DATA_WIDTH, 64, data bus width in bits.
- ADDR_WIDTH, DATA_WIDTH, byte-address width.
- DATA_BYTES, DATA_WIDTH/8, byte-enable width.
- MAX_WAIT, 8, consecutive denied cycles of port 1 before it is forced to win one grant; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- p0_req  input  1  port 0 request valid.
- p0_lock  input  1  port 0 keeps ownership after this beat.
- p0_addr  input  ADDR_WIDTH  port 0 byte address.
- p0_wdata  input  DATA_WIDTH  port 0 write data.
- p0_wen  input  DATA_BYTES  port 0 byte write enables; 0 means read.
- p0_gnt  output  1  port 0 beat accepted this cycle (combinational).
- p0_rvalid  output  1  port 0 response valid (one cycle after grant).
- p0_rdata  output  DATA_WIDTH  port 0 response data.
- p1_req, p1_lock, p1_addr, p1_wdata, p1_wen, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- m_addr  output  ADDR_WIDTH  memory address.
- m_wdata  output  DATA_WIDTH  memory write data.
- m_wen  output  DATA_BYTES  memory byte enables.
- m_rdata  input  DATA_WIDTH  memory read data, valid the cycle after the address is presented.

Behaviour:
- Reset (async, active-high):
  - state=ARB, wait_cnt=0, rsp_valid=0, rsp_port=0.
  - pN_rvalid=0, pN_rdata=0.
  - m_wen=0, m_addr=0, m_wdata=0.
- Grant is combinational from current state and requests. At most one pN_gnt is high per cycle.
- The granted port's addr/wdata/wen drive m_*. With no grant: m_wen=0 and m_addr/m_wdata=0.
- FSM states: ARB, LOCK0, LOCK1.
  - ARB:
    - If p1_req && wait_cnt==MAX_WAIT, grant port 1.
    - Else if p0_req, grant port 0.
    - Else if p1_req, grant port 1.
  - LOCKn: only port n may be granted. The other port is held off regardless of wait_cnt.
  - Transition on a granted beat with pN_lock=1: enter/stay LOCKN.
  - Transition on a granted beat with pN_lock=0: return to ARB.
  - In LOCKn with pn_req=0: return to ARB next cycle; no grant that cycle.
  - pN_lock is ignored when pN_req=0 or the port is not granted.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle p1_req=1 && p1_gnt=0.
  - Clears on p1_gnt.
  - Clears when p1_req=0.
  - Width $clog2(MAX_WAIT+1).
- Response path:
  - Every granted beat, read or write, registers rsp_valid=1 and rsp_port=granted port.
  - Next cycle: prsp_port_rvalid=1 and prsp_port_rdata=m_rdata. For writes this is an acknowledge, and the data equals the written-merged word (write-first).
  - Non-selected port: rvalid=0, rdata holds its last value.
  - Throughput is one beat per cycle. Back-to-back grants to alternating ports produce back-to-back responses in the same order.
- Simultaneous requests in ARB with wait_cnt<MAX_WAIT: port 0 wins and port 1 wait_cnt increments.
- Forced port-1 grant: one beat only. wait_cnt clears, and port 0 wins again next cycle unless port 1 asserted lock.
- Requesters must hold req/addr/wdata/wen/lock stable until gnt. The arbiter does not buffer requests.
- Reset asserted mid-sequence (locked or with a response pending): the pending response is dropped, no rvalid is issued, and state returns to ARB.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: adds outputs o_gnt0_cnt, o_gnt1_cnt, o_conflict_cnt (32 bits each, wrapping).
  - o_gnt0_cnt / o_gnt1_cnt increment on each pN_gnt.
  - o_conflict_cnt increments on each cycle with both requests high and exactly one grant, including locked hold-off.
  - All three reset to 0.
- Undefined: these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Single read: p0 read addr 0x18, m_rdata=0xDEAD next cycle -> p0_gnt same cycle, p0_rvalid=1 with p0_rdata=0xDEAD one cycle later, p1_rvalid=0.
- Simultaneous: p0 and p1 request continuously, MAX_WAIT=8 -> p0 granted 8 cycles, p1 granted on cycle 9, pattern repeats (8:1); wait_cnt never exceeds 8.
- Lock: p1 forced-granted with lock=1 for 3 beats then lock=0, p0 requesting throughout -> p0_gnt=0 for all 4 p1 beats; p0 granted on the following cycle.
- Lock drop: in LOCK0, p0_req falls for one cycle -> no grant that cycle, ARB next cycle, p1 granted if requesting.
- Write ack: p1 write wen=0xFF wdata=0x1234 to 0x40 -> m_wen=0xFF same cycle; p1_rvalid=1 next cycle; no p0_rvalid.
- Reset mid-flight: rst asserted the cycle after a p0 grant -> p0_rvalid stays 0, all outputs at reset values, state ARB after release.
